// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: default widths, reset PC and the
// fetch/issue state encoding.
package cpu_pkg;

  localparam int unsigned CPU_PC_W     = 8;
  localparam logic [7:0]  CPU_RESET_PC = 8'h00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    ISSUE  = 2'd2,
    HALTED = 2'd3
  } state_t;

endpackage

// File: rtl/pc_incrementer.sv
// Next-sequential-PC adder; the carry out is dropped so the PC wraps.
module pc_incrementer #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] pc_in,
  output logic [W-1:0] pc_out
);

  assign pc_out = pc_in + W'(1);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetches one instruction at a time from imem,
// issues it to decode and resolves stall/halt/branch on the way out.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W     = CPU_PC_W,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(CPU_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            halt,
  input  logic            resume,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [PC_W-1:0] imem_rdata,
  output logic [PC_W-1:0] instr,
  output logic            instr_valid,
  output logic [PC_W-1:0] pc,
  output logic            halted
);

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc_nxt, instr_nxt, pc_inc;

  pc_incrementer #(.W(PC_W)) u_inc (
    .pc_in  (pc),
    .pc_out (pc_inc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= RESET_PC;
      instr <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      instr <= instr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    instr_nxt   = instr;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    unique case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_nxt = imem_rdata;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        instr_valid = 1'b1;
        // stall outranks everything: the issued instruction and PC stay put
        if (!stall) begin
          if (halt) begin
            pc_nxt    = pc_inc;
            state_nxt = HALTED;
          end else if (branch_taken) begin
            pc_nxt    = branch_target;
            state_nxt = FETCH;
          end else begin
            pc_nxt    = pc_inc;
            state_nxt = FETCH;
          end
        end
      end
      HALTED: begin
        halted = 1'b1;
        if (resume) state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign imem_addr = pc;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 8, meaning PC, address and instruction width in bits.
REQ-002 SHALL have parameter RESET_PC, default 8'h00, meaning PC value loaded on reset.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port stall, input, 1, meaning hold current instruction and PC.
REQ-006 SHALL have port halt, input, 1, meaning the issued instruction is HALT.
REQ-007 SHALL have port resume, input, 1, meaning leave HALTED.
REQ-008 SHALL have port branch_taken, input, 1, meaning load branch_target instead of PC+1.
REQ-009 SHALL have port branch_target, input, PC_W, meaning absolute next PC.
REQ-010 SHALL have port imem_req, output, 1, meaning instruction-memory read request.
REQ-011 SHALL have port imem_addr, output, PC_W, meaning read address, always equal to pc.
REQ-012 SHALL have port imem_ack, input, 1, meaning imem_rdata valid this cycle.
REQ-013 SHALL have port imem_rdata, input, PC_W, meaning fetched instruction.
REQ-014 SHALL have port instr, output, PC_W, meaning registered current instruction.
REQ-015 SHALL have port instr_valid, output, 1, meaning instr is issued to decode.
REQ-016 SHALL have port pc, output, PC_W, meaning registered program counter.
REQ-017 SHALL have port halted, output, 1, meaning FSM in HALTED.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH, ISSUE, HALTED.
REQ-019 SHALL move IDLE -> FETCH unconditionally after one cycle.
REQ-020 SHALL hold imem_req=1 throughout FETCH, with imem_addr stable, until imem_ack; no timeout.
REQ-021 SHALL, on FETCH with imem_ack=1, register imem_rdata into instr and enter ISSUE next cycle (min fetch latency: ack in first FETCH cycle -> instr_valid one cycle later).
REQ-022 SHALL drive instr_valid=1 exactly while in ISSUE, and imem_req=0 outside FETCH.
REQ-023 SHALL resolve ISSUE with priority stall > halt > branch_taken > increment.
REQ-024 SHALL, on stall=1 in ISSUE, remain in ISSUE with pc and instr unchanged.
REQ-025 SHALL, on halt=1 (no stall), set pc <= pc+1 and enter HALTED.
REQ-026 SHALL, on branch_taken=1 (no stall, no halt), set pc <= branch_target and enter FETCH.
REQ-027 SHALL otherwise set pc <= pc+1 and enter FETCH.
REQ-028 SHALL wrap pc+1 modulo 2^PC_W (8'hFF -> 8'h00), carry discarded.
REQ-029 SHALL ignore branch_taken, halt and stall outside ISSUE, and imem_ack outside FETCH.
REQ-030 SHALL, in HALTED, keep pc frozen, halted=1, and go to FETCH on resume=1.

Reset
REQ-031 SHALL, while rst_n=0, asynchronously force state IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, halted=0.
REQ-032 SHALL abort any outstanding fetch on reset; a late imem_ack after release SHALL be ignored unless in FETCH.
REQ-033 SHALL release synchronously: first active edge after rst_n rises is spent in IDLE.

Structure
REQ-034 SHALL place PC_W, RESET_PC default and the state encoding (2-bit, IDLE=0, FETCH=1, ISSUE=2, HALTED=3) in shared package cpu_pkg.
REQ-035 SHALL instantiate one combinational sub-module pc_incrementer (pc_in -> pc_in+1) for the next-PC adder.

Verification
REQ-036 SHALL test straight-line fetch: reset, ack each FETCH in 1st cycle with rdata=8'h10+addr -> instr sequence 10,11,12, pc 00,01,02, instr_valid one cycle each.
REQ-037 SHALL test branch: in ISSUE at pc=05, branch_taken=1, target=8'h40 -> next imem_addr=40.
REQ-038 SHALL test wrap and stall: pc=FF, stall 3 cycles -> instr_valid held 3+1 cycles, pc stays FF, then pc=00.
REQ-039 SHALL test halt/resume: halt at pc=07 -> halted=1, pc=08, no imem_req; resume -> fetch at 08.
REQ-040 SHALL test reset mid-fetch: rst_n low while imem_req=1, ack delayed 4 cycles -> imem_req drops immediately, pc=RESET_PC, no instr_valid until fresh fetch.
REQ-041 SHALL test priority: stall=1, halt=1, branch_taken=1 together in ISSUE -> no change; drop stall -> HALTED, pc=pc+1.
